// File: rtl/vseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vseq_pkg
//  Description : Shared types and constants for the vector op sequencer:
//                FSM state encoding, ALU op / register select codes and the
//                latched command record.
//  Revision    : 1.0  initial release
// ============================================================================
package vseq_pkg;

    // Word-address width of the processor memory (512 words).
    localparam int VSEQ_ADDR_W = 9;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_A1 = 3'd1,
        LD_A2 = 3'd2,
        EXEC  = 3'd3,
        ST_A3 = 3'd4,
        ST_A4 = 3'd5,
        DONE  = 3'd6
    } vseq_state_t;

    // ALU operation codes.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Register-file select: low pair (A1/A3) or high pair (A2/A4).
    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    // One accepted command, captured on the accepting edge.
    typedef struct packed {
        logic [VSEQ_ADDR_W-1:0] src_a;
        logic [VSEQ_ADDR_W-1:0] src_b;
        logic [VSEQ_ADDR_W-1:0] dst;
        logic                   op;
        logic                   store_hi;
    } vseq_cmd_t;

    localparam int VSEQ_CMD_W = $bits(vseq_cmd_t);

endpackage : vseq_pkg
`default_nettype wire

// File: rtl/vseq_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vseq_cmd_fifo
//  Description : Two-entry command FIFO for the vector op sequencer. A push
//                on a full FIFO is accepted when a pop happens in the same
//                cycle (pop first). Only built when VSEQ_CMD_FIFO_EN is
//                defined, since it is only instantiated in that build.
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef VSEQ_CMD_FIFO_EN
module vseq_cmd_fifo
    import vseq_pkg::*;
#(
    parameter int WIDTH = VSEQ_CMD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == 2'd0);
    assign full      = (r_count == 2'd2);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : vseq_cmd_fifo
`endif
`default_nettype wire

// File: rtl/vector_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_op_sequencer
//  Description : Command-level controller for the 512-bit vector datapath.
//                Accepts a command and steps the processor control pins
//                through load A1, load A2, execute, store A3 (and A4).
//                Optional macro VSEQ_CMD_FIFO_EN adds a 2-entry command
//                FIFO so commands can be accepted while busy.
//  Revision    : 1.0  initial release
// ============================================================================
module vector_op_sequencer
    import vseq_pkg::*;
#(
    // The command record is sized from VSEQ_ADDR_W, so ADDR_W must match it.
    parameter int ADDR_W     = VSEQ_ADDR_W,
    parameter int MEM_RD_LAT = 1,
    parameter int ALU_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              cmd_op,
    input  logic              cmd_store_hi,
    output logic [ADDR_W-1:0] proc_address,
    output logic              proc_we,
    output logic              proc_select,
    output logic              proc_op_enable,
    output logic              proc_op,
    output logic              busy,
    output logic              done
);

    localparam int WAIT_MAX = (MEM_RD_LAT > ALU_LAT) ? MEM_RD_LAT : ALU_LAT;
    localparam int WAIT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] c_LD_LAST = WAIT_W'(MEM_RD_LAT);
    localparam logic [WAIT_W-1:0] c_EX_LAST = WAIT_W'(ALU_LAT);

    vseq_state_t       r_state;
    vseq_state_t       w_next_state;
    logic [WAIT_W-1:0] r_wait;
    vseq_cmd_t         r_cmd;
    vseq_cmd_t         w_in_cmd;
    vseq_cmd_t         w_new_cmd;
    vseq_cmd_t         w_act_cmd;
    logic              w_accept;
    logic              w_start;

    logic [ADDR_W-1:0] w_address;
    logic              w_we;
    logic              w_select;
    logic              w_op_enable;
    logic              w_op;
    logic              w_done;

    assign w_in_cmd = {cmd_src_a, cmd_src_b, cmd_dst, cmd_op, cmd_store_hi};
    assign w_accept = cmd_valid && cmd_ready;
    assign busy     = (r_state != IDLE);

`ifdef VSEQ_CMD_FIFO_EN
    logic      w_fifo_empty;
    logic      w_fifo_full;
    logic      w_fifo_push;
    logic      w_fifo_pop;
    vseq_cmd_t w_fifo_head;

    // A new command may start from IDLE or straight out of DONE. When the
    // FIFO is empty the incoming command bypasses it so the start latency
    // matches the unqueued build.
    assign cmd_ready   = !w_fifo_full && !rst;
    assign w_start     = ((r_state == IDLE) || (r_state == DONE)) &&
                         (!w_fifo_empty || w_accept);
    assign w_new_cmd   = w_fifo_empty ? w_in_cmd : w_fifo_head;
    assign w_fifo_pop  = w_start && !w_fifo_empty;
    assign w_fifo_push = w_accept && !(w_start && w_fifo_empty);

    vseq_cmd_fifo #(
        .WIDTH (VSEQ_CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fifo_push),
        .din   (w_in_cmd),
        .pop   (w_fifo_pop),
        .dout  (w_fifo_head),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );
`else
    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_start   = (r_state == IDLE) && w_accept;
    assign w_new_cmd = w_in_cmd;
`endif

    // Outputs are decoded from the next state, so the command being started
    // this edge must be visible before it lands in r_cmd.
    assign w_act_cmd = w_start ? w_new_cmd : r_cmd;

    // Command latch: captured once when a command starts, held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (w_start) begin
            r_cmd <= w_new_cmd;
        end
    end

    // State register and per-state wait counter (restarts on every change).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= (w_next_state != r_state) ? '0 : r_wait + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = LD_A1;
            LD_A1:   if (r_wait == c_LD_LAST) w_next_state = LD_A2;
            LD_A2:   if (r_wait == c_LD_LAST) w_next_state = EXEC;
            EXEC:    if (r_wait == c_EX_LAST) w_next_state = ST_A3;
            ST_A3:   w_next_state = r_cmd.store_hi ? ST_A4 : DONE;
            ST_A4:   w_next_state = DONE;
            DONE:    w_next_state = w_start ? LD_A1 : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode for the state being entered; address is constant per state.
    always_comb begin
        w_address   = '0;
        w_we        = 1'b0;
        w_select    = SEL_LO;
        w_op_enable = 1'b0;
        w_op        = OP_ADD;
        w_done      = 1'b0;
        case (w_next_state)
            LD_A1: begin
                w_address = w_act_cmd.src_a;
            end
            LD_A2: begin
                w_address = w_act_cmd.src_b;
                w_select  = SEL_HI;
            end
            EXEC: begin
                w_op_enable = 1'b1;
                w_op        = w_act_cmd.op;
            end
            ST_A3: begin
                w_address = w_act_cmd.dst;
                w_we      = 1'b1;
            end
            ST_A4: begin
                w_address = w_act_cmd.dst + ADDR_W'(1);
                w_we      = 1'b1;
                w_select  = SEL_HI;
            end
            DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_address = '0;
            end
        endcase
    end

    // Registered control outputs; reset clears them on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            proc_address   <= '0;
            proc_we        <= 1'b0;
            proc_select    <= SEL_LO;
            proc_op_enable <= 1'b0;
            proc_op        <= OP_ADD;
            done           <= 1'b0;
        end else begin
            proc_address   <= w_address;
            proc_we        <= w_we;
            proc_select    <= w_select;
            proc_op_enable <= w_op_enable;
            proc_op        <= w_op;
            done           <= w_done;
        end
    end

endmodule : vector_op_sequencer
`default_nettype wire

// File: tb/tb_vector_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_op_sequencer
//  Description : Self-checking bench for vector_op_sequencer (unqueued
//                build). Expected per-cycle control vectors are queued when
//                a command is driven and compared cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_op_sequencer;

    localparam int LD_CYC = 2;   // MEM_RD_LAT + 1 at MEM_RD_LAT = 1
    localparam int EX_CYC = 2;   // ALU_LAT + 1 at ALU_LAT = 1

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_src_a;
    logic [8:0] cmd_src_b;
    logic [8:0] cmd_dst;
    logic       cmd_op;
    logic       cmd_store_hi;
    logic [8:0] proc_address;
    logic       proc_we;
    logic       proc_select;
    logic       proc_op_enable;
    logic       proc_op;
    logic       busy;
    logic       done;

    // Observed vector layout: {addr[8:0], we, sel, op_en, op, done, busy, ready}
    typedef struct packed {
        logic [15:0] val;
        logic [15:0] mask;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    vector_op_sequencer #(
        .ADDR_W     (9),
        .MEM_RD_LAT (1),
        .ALU_LAT    (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_src_a      (cmd_src_a),
        .cmd_src_b      (cmd_src_b),
        .cmd_dst        (cmd_dst),
        .cmd_op         (cmd_op),
        .cmd_store_hi   (cmd_store_hi),
        .proc_address   (proc_address),
        .proc_we        (proc_we),
        .proc_select    (proc_select),
        .proc_op_enable (proc_op_enable),
        .proc_op        (proc_op),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog against any unexpected stall of the directed sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic item_t mk(input logic [8:0] addr, input logic ca,
                                 input logic we, input logic sel, input logic cs,
                                 input logic oe, input logic op, input logic co,
                                 input logic dn, input logic bs, input logic rd);
        item_t it;
        it.val  = {addr, we, sel, oe, op, dn, bs, rd};
        it.mask = {{9{ca}}, 1'b1, cs, 1'b1, co, 1'b1, 1'b1, 1'b1};
        return it;
    endfunction

    // Expected control trace of one command, one entry per cycle after accept.
    task automatic push_trace(input logic [8:0] a, input logic [8:0] b,
                              input logic [8:0] d, input logic op, input logic hi);
        logic [8:0] d1;
        d1 = d + 9'd1;
        for (int i = 0; i < LD_CYC; i++) q.push_back(mk(a, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < LD_CYC; i++) q.push_back(mk(b, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < EX_CYC; i++) q.push_back(mk(9'd0, 0, 0, 0, 0, 1, op, 1, 0, 1, 0));
        q.push_back(mk(d, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        if (hi) q.push_back(mk(d1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0));
        q.push_back(mk(9'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    endtask

    task automatic push_idle();
        q.push_back(mk(9'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic push_reset();
        q.push_back(mk(9'd0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    endtask

    task automatic check_now(input string tag);
        item_t       e;
        logic [15:0] obs;
        obs = {proc_address, proc_we, proc_select, proc_op_enable, proc_op, done, busy, cmd_ready};
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = q.pop_front();
            assert ((obs & e.mask) === (e.val & e.mask)) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h mask=%h", tag, obs, e.val, e.mask);
            end
        end
    endtask

    // Drain everything queued, one comparison per cycle.
    task automatic drain(input string tag);
        check_now(tag);
        while (q.size() > 0) begin
            @(negedge clk);
            check_now(tag);
        end
    endtask

    task automatic drive(input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] d, input logic op, input logic hi);
        cmd_valid    = 1'b1;
        cmd_src_a    = a;
        cmd_src_b    = b;
        cmd_dst      = d;
        cmd_op       = op;
        cmd_store_hi = hi;
    endtask

    // Issue one command from IDLE at a negedge, then check through IDLE again.
    task automatic run_cmd(input string tag, input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] d, input logic op, input logic hi);
        drive(a, b, d, op, hi);
        push_trace(a, b, d, op, hi);
        push_idle();
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_src_a = 9'h1ff;
        cmd_dst   = 9'h1ff;
        drain(tag);
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_src_a    = '0;
        cmd_src_b    = '0;
        cmd_dst      = '0;
        cmd_op       = 1'b0;
        cmd_store_hi = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_reset();
        check_now("reset_state");
        rst = 1'b0;
        @(negedge clk);
        push_idle();
        check_now("idle_after_reset");

        // Basic add with both stores: 5,5,6,6,x,x,10,11 then done.
        run_cmd("cmd_add_hi", 9'd5, 9'd6, 9'd10, 1'b0, 1'b1);

        // Destination at top of memory: A4 wraps to address 0.
        run_cmd("cmd_wrap", 9'd100, 9'd200, 9'd511, 1'b0, 1'b1);

        // Multiply, low store only: done one cycle earlier.
        run_cmd("cmd_mul_lo", 9'd33, 9'd44, 9'd77, 1'b1, 1'b0);

        // Same source word for both operands.
        run_cmd("cmd_same_src", 9'd7, 9'd7, 9'd20, 1'b1, 1'b1);

        // valid held high: second command accepted the cycle after done.
        drive(9'd1, 9'd2, 9'd3, 1'b0, 1'b0);
        push_trace(9'd1, 9'd2, 9'd3, 1'b0, 1'b0);
        push_idle();
        @(posedge clk);
        @(negedge clk);
        drive(9'd300, 9'd301, 9'd302, 1'b1, 1'b1);
        drain("b2b_first");
        push_trace(9'd300, 9'd301, 9'd302, 1'b1, 1'b1);
        push_idle();
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        drain("b2b_second");

        // Reset held three cycles starting in the middle of EXEC.
        drive(9'd50, 9'd60, 9'd70, 1'b1, 1'b1);
        push_trace(9'd50, 9'd60, 9'd70, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2 * LD_CYC + 1; i++) begin
            check_now("pre_reset");
            if (i < 2 * LD_CYC) @(negedge clk);
        end
        q.delete();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_reset();
            check_now("mid_exec_reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            push_idle();
            check_now("post_reset_quiet");
        end

        // Recovery after abort.
        run_cmd("cmd_after_reset", 9'd8, 9'd9, 9'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vector_op_sequencer
`default_nettype wire
